uart_rx_oversampled: RTL and testbench

Serial receive front end of the MCU UART. It synchronises `serial_in`, generates the 16x oversampling tick, and deframes 8N1 characters (optionally 8E1). Each completed byte is presented in a one-entry holding register with a valid/ack handshake, so the downstream MMIO/FIFO stage can consume it. It sits between the `serial_in` pin of `mcu_top` and the receive data register.

---
 rtl/uart_rx_oversampled.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Completed bytes land in a one-entry holding register with a valid/ack handshake.
module uart_rx_oversampled #(
    parameter int DVSR    = 26,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            serial_in,
    input  logic            rx_ack,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    output logic            overrun,
    output logic            frame_err,
    output logic            parity_err
);
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DVSR - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [3:0]    S_MID     = 4'd7;
    localparam logic [3:0]    S_LAST    = 4'd15;
    localparam logic [3:0]    S_STOP    = 4'(SB_TICK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    state_t        state;
    logic [3:0]    s;
    logic [NW-1:0] n;
    logic [DBIT-1:0] b;
    logic          stop_hit;
    logic          deliver;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    // NOTE: non-blocking assignments keep sync1 and rx_s as two distinct flops;
    // blocking ones would let serial_in fall straight through to rx_s.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx_s  <= sync1;
        end
    end

    assign tick = (div_cnt == TICK_LAST);

    always_ff @(posedge CLOCK) begin
        if (!RESET) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            n <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s       <= '0;
                            par_bad <= (rx_s != ^b);
                            state   <= STOP;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            s <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
                                state      <= IDLE;
`endif
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                // A held break would otherwise look like an endless run of start bits.
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_hit = (state == STOP) && tick && (s == S_STOP);

`ifdef UART_RX_PARITY_EN
    assign deliver = stop_hit && rx_s && !par_bad;
`else
    assign deliver    = stop_hit && rx_s;
    assign parity_err = 1'b0;
`endif

    // NOTE: rx_data is a single register, not a memory, so it is reset along
    // with the flags and reads 0 until the first byte arrives.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (deliver) begin
            if (!rx_valid || rx_ack) begin
                rx_data  <= b;
                rx_valid <= 1'b1;
                overrun  <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled; honours UART_RX_PARITY_EN the same way as the RTL.
module tb_uart_rx_oversampled;
    localparam int BIT_CLKS = 416;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_CLKS = (10 + PAR_BITS) * BIT_CLKS;
    localparam int LAT_LO     = 3928 + PAR_BITS * BIT_CLKS;
    localparam int LAT_HI     = 3957 + PAR_BITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err, parity_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] got_q[$];
    int  n_rise = 0, n_fall = 0, n_ferr = 0, ferr_cyc = 0, n_perr = 0, perr_cyc = 0;
    int  rise_cyc = 0, last_start_cyc = 0;
    bit  ovr_seen = 0, auto_ack = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit  bad_par = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_oversampled dut (
        .CLOCK      (clk),
        .RESET      (rst_n),
        .serial_in  (serial_in),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // Observes outputs mid-cycle; optionally acks each new byte one clock after it appears.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            got_q.push_back(rx_data);
            n_rise++;
            rise_cyc = cyc;
        end
        if (rx_valid !== 1'b1 && prev_valid === 1'b1) n_fall++;
        if (frame_err === 1'b1) begin
            ferr_cyc++;
            if (prev_ferr !== 1'b1) n_ferr++;
        end
        if (parity_err === 1'b1) begin
            perr_cyc++;
            if (prev_perr !== 1'b1) n_perr++;
        end
        if (overrun === 1'b1) ovr_seen = 1;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
        prev_perr  = parity_err;
        if (auto_ack) rx_ack = (rx_valid === 1'b1) && !rx_ack;
    end

    // Must be called just after a falling clock edge; returns with the line at stop_bit.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        logic [7:0] v;
        v = d;
        serial_in = 1'b0;
        last_start_cyc = cyc;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = v[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        serial_in = (^v) ^ bad_par;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        serial_in = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else passed++;
        total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", parity_err); else passed++;
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        total++; if (n_rise !== 0) $display("FAIL reset_idle_no_valid: got %0d delivers expected 0", n_rise); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        int q0, f0, p0, lat;
        exp_b = '{8'h05, 8'h0A, 8'h0C};
        q0 = got_q.size(); f0 = n_ferr; p0 = n_perr;
        ovr_seen = 0; auto_ack = 1;
        send_byte(exp_b[0], 1'b1);
        lat = rise_cyc - last_start_cyc;
        send_byte(exp_b[1], 1'b1);
        send_byte(exp_b[2], 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (got_q.size() - q0 !== 3) $display("FAIL b2b_count: got %0d expected 3", got_q.size() - q0); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q.size() <= q0 + i) $display("FAIL b2b_byte%0d: got none expected %h", i, exp_b[i]);
            else if (got_q[q0 + i] !== exp_b[i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[q0 + i], exp_b[i]);
            else passed++;
        end
        total++; if (lat < LAT_LO || lat > LAT_HI) $display("FAIL b2b_latency: got %0d expected %0d..%0d", lat, LAT_LO, LAT_HI); else passed++;
        total++; if (ovr_seen !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", ovr_seen); else passed++;
        total++; if (n_ferr !== f0) $display("FAIL b2b_frame_err: got %0d pulses expected 0", n_ferr - f0); else passed++;
        total++; if (n_perr !== p0) $display("FAIL b2b_parity_err: got %0d pulses expected 0", n_perr - p0); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL b2b_acked: got rx_valid %b expected 0", rx_valid); else passed++;
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = n_rise; f0 = n_ferr;
        serial_in = 1'b0;
        repeat (3 * 26) @(negedge clk);
        serial_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        total++; if (n_rise !== r0) $display("FAIL glitch_no_valid: got %0d delivers expected 0", n_rise - r0); else passed++;
        total++; if (n_ferr !== f0) $display("FAIL glitch_no_frame_err: got %0d pulses expected 0", n_ferr - f0); else passed++;
        send_byte(8'hC3, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_rise - r0 !== 1 || got_q[$] !== 8'hC3) $display("FAIL glitch_then_byte: got %0d delivers last %h expected 1 of c3", n_rise - r0, got_q[$]); else passed++;
    endtask

    task automatic test_break();
        int r0, f0, fc0;
        r0 = n_rise; f0 = n_ferr; fc0 = ferr_cyc;
        send_byte(8'hA5, 1'b0);
        repeat (2000) @(negedge clk);
        total++; if (n_ferr - f0 !== 1) $display("FAIL break_frame_err_pulses: got %0d expected 1", n_ferr - f0); else passed++;
        total++; if (ferr_cyc - fc0 !== 1) $display("FAIL break_frame_err_width: got %0d clocks expected 1", ferr_cyc - fc0); else passed++;
        total++; if (n_rise !== r0) $display("FAIL break_no_valid: got %0d delivers expected 0", n_rise - r0); else passed++;
        serial_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_rise - r0 !== 1 || got_q[$] !== 8'h3C) $display("FAIL break_recover: got %0d delivers last %h expected 1 of 3c", n_rise - r0, got_q[$]); else passed++;
        total++; if (n_ferr - f0 !== 1) $display("FAIL break_recover_frame_err: got %0d pulses expected 1", n_ferr - f0); else passed++;
    endtask

    task automatic test_overrun();
        int r1, fall0;
        auto_ack = 0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        total++; if (rx_data !== 8'h11) $display("FAIL ovr_keep_old: got %h expected 11", rx_data); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else passed++;
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b expected 0", rx_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b expected 0", overrun); else passed++;
        send_byte(8'h11, 1'b1);
        r1 = rise_cyc;
        fall0 = n_fall;
        // Frames are a whole number of ticks long, so the second deliver lands exactly one frame later.
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (r1 + FRAME_CLKS - 1 - cyc) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        total++; if (rx_data !== 8'h22) $display("FAIL ovr_same_cycle_data: got %h expected 22", rx_data); else passed++;
        total++; if (rx_valid !== 1'b1) $display("FAIL ovr_same_cycle_valid: got %b expected 1", rx_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL ovr_same_cycle_flag: got %b expected 0", overrun); else passed++;
        total++; if (n_fall !== fall0) $display("FAIL ovr_same_cycle_no_gap: got %0d valid drops expected 0", n_fall - fall0); else passed++;
    endtask

    task automatic test_mid_frame_reset();
        int r0;
        r0 = n_rise;
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
                rst_n = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) $display("FAIL midreset_cleared: got valid %b data %h expected 0 00", rx_valid, rx_data); else passed++;
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_rise !== r0) $display("FAIL midreset_no_deliver: got %0d delivers expected 0", n_rise - r0); else passed++;
        auto_ack = 1;
        send_byte(8'h66, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_rise - r0 !== 1 || got_q[$] !== 8'h66) $display("FAIL midreset_next_byte: got %0d delivers last %h expected 1 of 66", n_rise - r0, got_q[$]); else passed++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int r0, p0, pc0;
        r0 = n_rise; p0 = n_perr; pc0 = perr_cyc;
        auto_ack = 1;
        bad_par = 1;
        send_byte(8'h07, 1'b1);
        bad_par = 0;
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_perr - p0 !== 1) $display("FAIL parity_pulses: got %0d expected 1", n_perr - p0); else passed++;
        total++; if (perr_cyc - pc0 !== 1) $display("FAIL parity_width: got %0d clocks expected 1", perr_cyc - pc0); else passed++;
        total++; if (n_rise !== r0) $display("FAIL parity_no_valid: got %0d delivers expected 0", n_rise - r0); else passed++;
        send_byte(8'h07, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (n_rise - r0 !== 1 || got_q[$] !== 8'h07) $display("FAIL parity_good_byte: got %0d delivers last %h expected 1 of 07", n_rise - r0, got_q[$]); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_mid_frame_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
